// File: rtl/ifu_prefetch_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus EXU issue handshake.
// The master modport is the prefetch unit; the slave modport is memory/EXU side.
interface ifu_prefetch_if #(
   parameter int unsigned PC_SIZE     = 32,
   parameter int unsigned INSTR_SIZE  = 32,
   parameter int unsigned RFIDX_WIDTH = 5
);
   logic                   ifu_req_valid;
   logic                   ifu_req_ready;
   logic [PC_SIZE-1:0]     ifu_req_pc;
   logic                   ifu_rsp_valid;
   logic                   ifu_rsp_ready;
   logic [INSTR_SIZE-1:0]  ifu_rsp_instr;
   logic                   ifu_o_valid;
   logic                   ifu_o_ready;
   logic [INSTR_SIZE-1:0]  ifu_o_ir;
   logic [PC_SIZE-1:0]     ifu_o_pc;
   logic [RFIDX_WIDTH-1:0] ifu_o_rs1idx;
   logic [RFIDX_WIDTH-1:0] ifu_o_rs2idx;

   modport master (
      output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
      output ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_rs1idx, ifu_o_rs2idx,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_o_ready
   );

   modport slave (
      input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
      input  ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_rs1idx, ifu_o_rs2idx,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_o_ready
   );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: issues sequential fetches ahead of the EXU and buffers
// returned instructions with their PCs in a fall-through FIFO; redirect flushes everything.
module ifu_prefetch #(
   parameter int unsigned PC_SIZE         = 32,
   parameter int unsigned INSTR_SIZE      = 32,
   parameter int unsigned RFIDX_WIDTH     = 5,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [PC_SIZE-1:0]                 pc_rtvec,
   input  logic                               redirect_valid,
   input  logic [PC_SIZE-1:0]                 redirect_pc,
   output logic [PC_SIZE-1:0]                 inspect_pc,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   ifu_prefetch_if.master                     bus
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned OS_W  = $clog2(MAX_OUTSTANDING + 1);

   logic [PC_SIZE-1:0]    r_fetch_pc;
   logic [PC_SIZE-1:0]    r_rsp_pc;
   logic [OS_W-1:0]       r_outstanding;
   logic [OS_W-1:0]       r_drop_cnt;
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [INSTR_SIZE-1:0] r_fifo_ir [FIFO_DEPTH];
   logic [PC_SIZE-1:0]    r_fifo_pc [FIFO_DEPTH];

   logic [OS_W-1:0]       w_live;
   logic [SUM_W-1:0]      w_slots_used;
   logic                  w_req_valid;
   logic                  w_o_valid;
   logic                  w_req_fire;
   logic                  w_rsp_fire;
   logic                  w_o_fire;
   logic                  w_push;
   logic                  w_drop;
   logic [INSTR_SIZE-1:0] w_head_ir;

   // Slots are reserved at issue: every live in-flight response already owns a FIFO entry.
   assign w_live       = r_outstanding - r_drop_cnt;
   assign w_slots_used = SUM_W'(r_count) + SUM_W'(w_live);
   assign w_req_valid  = !rst && !redirect_valid
                         && (r_outstanding < OS_W'(MAX_OUTSTANDING))
                         && (w_slots_used < SUM_W'(FIFO_DEPTH));
   assign w_o_valid    = (r_count != '0) && !redirect_valid && !rst;

   assign w_req_fire = w_req_valid && bus.ifu_req_ready;
   assign w_rsp_fire = bus.ifu_rsp_valid;
   assign w_o_fire   = w_o_valid && bus.ifu_o_ready;
   assign w_drop     = w_rsp_fire && (r_drop_cnt != '0);
   assign w_push     = w_rsp_fire && (r_drop_cnt == '0) && !redirect_valid && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= pc_rtvec;
         r_rsp_pc      <= pc_rtvec;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
      end else if (redirect_valid) begin
         // Everything still in flight, minus a response landing now, becomes a drop.
         r_fetch_pc    <= redirect_pc;
         r_rsp_pc      <= redirect_pc;
         r_outstanding <= r_outstanding - OS_W'(w_rsp_fire);
         r_drop_cnt    <= r_outstanding - OS_W'(w_rsp_fire);
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + PC_SIZE'(4);
         end
         r_outstanding <= r_outstanding + OS_W'(w_req_fire) - OS_W'(w_rsp_fire);
         if (w_drop) begin
            r_drop_cnt <= r_drop_cnt - OS_W'(1);
         end
         if (w_push) begin
            r_wptr   <= r_wptr + PTR_W'(1);
            r_rsp_pc <= r_rsp_pc + PC_SIZE'(4);
         end
         if (w_o_fire) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_o_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_ir[r_wptr] <= bus.ifu_rsp_instr;
         r_fifo_pc[r_wptr] <= r_rsp_pc;
      end
   end

   assign w_head_ir = r_fifo_ir[r_rptr];

   assign bus.ifu_req_valid = w_req_valid;
   assign bus.ifu_req_pc    = r_fetch_pc;
   assign bus.ifu_rsp_ready = 1'b1;
   assign bus.ifu_o_valid   = w_o_valid;
   assign bus.ifu_o_ir      = w_head_ir;
   assign bus.ifu_o_pc      = r_fifo_pc[r_rptr];
   assign bus.ifu_o_rs1idx  = w_head_ir[15 +: RFIDX_WIDTH];
   assign bus.ifu_o_rs2idx  = w_head_ir[20 +: RFIDX_WIDTH];

   assign inspect_pc = r_fetch_pc;
   assign fifo_count = r_count;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised bench for ifu_prefetch: in-order memory model, queue-based reference of the
// delivered instruction stream, and a decoupled monitor scoring the EXU handshake.
module tb_ifu_prefetch;
   localparam int unsigned PCW   = 32;
   localparam int unsigned IW    = 32;
   localparam int unsigned RW    = 5;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned NCYC  = 4000;

   logic           clk = 1'b0;
   logic           rst;
   logic [PCW-1:0] pc_rtvec;
   logic           redirect_valid;
   logic [PCW-1:0] redirect_pc;
   logic [PCW-1:0] inspect_pc;
   logic [CW-1:0]  fifo_count;

   ifu_prefetch_if #(.PC_SIZE(PCW), .INSTR_SIZE(IW), .RFIDX_WIDTH(RW)) bus ();

   ifu_prefetch #(
      .PC_SIZE(PCW), .INSTR_SIZE(IW), .RFIDX_WIDTH(RW),
      .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inspect_pc(inspect_pc), .fifo_count(fifo_count), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int unsigned cyc;
      bit          live;
   } pend_t;

   pend_t       pend[$];      // accepted, unanswered memory requests
   logic [31:0] exp_q[$];     // PCs the EXU should still see, in order
   int          errors = 0;
   int          checks = 0;
   int          pops = 0;
   int          window_pops = 0;
   int unsigned cyc = 0;
   logic [31:0] model_pc;
   int          model_cnt;
   bit          known;
   int          occ, liv, rsp_prob;
   bit          rsp_live, req_fire, o_fire, exp_req_valid, exp_o_valid;

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return (pc ^ 32'hDEAD_BEEF) * 32'h9E37_79B1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   initial begin
      rst = 1'b1;
      pc_rtvec = 32'h8000_0000;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b0;
      bus.ifu_rsp_instr = '0;
      bus.ifu_o_ready = 1'b0;
      known = 1'b0;
      model_cnt = 0;
      model_pc = '0;

      for (int unsigned c = 0; c < NCYC; c++) begin
         @(negedge clk);
         cyc = c;
         occ = pend.size();
         liv = 0;
         foreach (pend[i]) if (pend[i].live) liv++;

         rst = (c < 3) || (c >= 1500 && c < 1502) || (c > 300 && $urandom_range(0, 999) == 0);
         if (rst && c >= 3) pc_rtvec = (c >= 1500 && c < 1502) ? 32'h0000_1000 : ($urandom() & 32'hFFFF_FFFC);

         if (c < 200) begin
            bus.ifu_req_ready = 1'b1; bus.ifu_o_ready = 1'b1; rsp_prob = 100;
         end else if (c < 260) begin
            bus.ifu_req_ready = 1'b1; bus.ifu_o_ready = 1'b0; rsp_prob = 100;
         end else begin
            bus.ifu_req_ready = ($urandom_range(0, 99) < 70);
            bus.ifu_o_ready   = ($urandom_range(0, 99) < 60);
            rsp_prob = 60;
         end

         redirect_valid = 1'b0;
         if (!rst) begin
            if (c == 100) begin
               redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
            end else if (c == 150) begin
               redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
            end else if (c >= 260 && $urandom_range(0, 99) < 4) begin
               redirect_valid = 1'b1; redirect_pc = $urandom() & 32'hFFFF_FFFC;
            end
         end

         bus.ifu_rsp_valid = 1'b0;
         rsp_live = 1'b0;
         if (!rst && pend.size() > 0 && pend[0].cyc < c && $urandom_range(0, 99) < rsp_prob) begin
            bus.ifu_rsp_valid = 1'b1;
            bus.ifu_rsp_instr = mk_instr(pend[0].pc);
            rsp_live = pend[0].live;
            void'(pend.pop_front());
         end

         #2;
         if (known) begin
            chk("fifo_count", 64'(fifo_count), 64'(model_cnt));
            chk("inspect_pc", 64'(inspect_pc), 64'(model_pc));
         end
         exp_req_valid = !rst && !redirect_valid && (occ < MAXO) && (model_cnt + liv < DEPTH);
         exp_o_valid   = (model_cnt != 0) && !redirect_valid && !rst;
         chk("req_valid", 64'(bus.ifu_req_valid), 64'(exp_req_valid));
         chk("o_valid", 64'(bus.ifu_o_valid), 64'(exp_o_valid));
         chk("rsp_ready", 64'(bus.ifu_rsp_ready), 64'(1));

         req_fire = bus.ifu_req_valid && bus.ifu_req_ready;
         o_fire   = bus.ifu_o_valid && bus.ifu_o_ready;
         if (req_fire) chk("req_pc", 64'(bus.ifu_req_pc), 64'(model_pc));

         if (rst) begin
            pend.delete(); exp_q.delete();
            model_cnt = 0; model_pc = pc_rtvec; known = 1'b1;
         end else if (redirect_valid) begin
            foreach (pend[i]) pend[i].live = 1'b0;
            exp_q.delete();
            model_cnt = 0; model_pc = redirect_pc;
         end else begin
            if (bus.ifu_rsp_valid && rsp_live) model_cnt++;
            if (o_fire) model_cnt--;
            if (req_fire) begin
               pend.push_back('{pc: model_pc, cyc: c, live: 1'b1});
               exp_q.push_back(model_pc);
               model_pc = model_pc + 32'd4;
            end
         end
      end

      @(negedge clk);
      #4;
      chk("steady_throughput", 64'(window_pops), 64'(80));
      chk("progress", 64'(pops > 500), 64'(1));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      logic [31:0] e;
      logic [31:0] ei;
      forever begin
         @(negedge clk);
         #3;
         if (bus.ifu_o_valid === 1'b1 && bus.ifu_o_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got pc %0h expected no output (cycle %0d)", bus.ifu_o_pc, cyc);
            end else begin
               e  = exp_q.pop_front();
               ei = mk_instr(e);
               chk("o_pc", 64'(bus.ifu_o_pc), 64'(e));
               chk("o_ir", 64'(bus.ifu_o_ir), 64'(ei));
               chk("o_rs1idx", 64'(bus.ifu_o_rs1idx), 64'(ei[19:15]));
               chk("o_rs2idx", 64'(bus.ifu_o_rs2idx), 64'(ei[24:20]));
               pops++;
               if (cyc >= 20 && cyc < 100) window_pops++;
            end
         end
      end
   end
endmodule
